ftdi_fifo_tx: RTL and testbench

- Write-side engine for the FT245-style asynchronous FTDI FIFO; the complement of the receive path that captures bytes from the FTDI bus into clock-enabled registers.
- Accepts bytes from fabric logic (BRAM/DDR readback) over a valid/ready handshake and buffers them in a small FIFO.
- Runs the FTDI write strobe sequence (WR#, TXE#) with programmable pulse timing, so the host receives the stream without loss.

---
 rtl/ftdi_fifo_tx.sv | 219 +++++++++++++++++++++
 tb/tb_ftdi_fifo_tx.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ftdi_fifo_tx.sv
// FT245-style FIFO write engine: buffers fabric bytes and drives the WR#/TXE# handshake.
// Optional send-immediate (SIWU#) support is enabled by defining FTDI_TX_SIWU_EN.
module ftdi_fifo_tx #(
    parameter int SIZE       = 8,
    parameter int DEPTH_LOG2 = 2,
    parameter int WR_LOW     = 3,
    parameter int WR_HIGH    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [SIZE-1:0]       in_b,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [SIZE-1:0]       ftdi_d_out,
    output logic                  ftdi_d_oe,
    output logic                  ftdi_wr_n,
    input  logic                  ftdi_txe_n,
`ifdef FTDI_TX_SIWU_EN
    input  logic                  flush,
    output logic                  ftdi_siwu_n,
`endif
    output logic                  busy,
    output logic [DEPTH_LOG2:0]   level
);

    localparam int                 DEPTH       = 1 << DEPTH_LOG2;
    localparam int                 CNT_W       = 8;
    localparam logic [DEPTH_LOG2:0] LVL_FULL   = (DEPTH_LOG2+1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0] LVL_ONE    = (DEPTH_LOG2+1)'(1);
    localparam logic [DEPTH_LOG2:0] LVL_ZERO   = (DEPTH_LOG2+1)'(0);
    localparam logic [CNT_W-1:0]   STROBE_LOAD = CNT_W'(WR_LOW - 1);
    localparam logic [CNT_W-1:0]   RECOV_LOAD  = CNT_W'(WR_HIGH - 1);
    localparam logic [CNT_W-1:0]   CNT_ZERO    = CNT_W'(0);
    localparam logic [CNT_W-1:0]   CNT_ONE     = CNT_W'(1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_SETUP   = 3'd1;
    localparam logic [2:0] S_STROBE  = 3'd2;
    localparam logic [2:0] S_HOLD    = 3'd3;
    localparam logic [2:0] S_RECOVER = 3'd4;

    logic                  r_txe_meta;
    logic                  r_txe_s;
    logic [SIZE-1:0]       r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] r_wptr;
    logic [DEPTH_LOG2-1:0] r_rptr;
    logic [DEPTH_LOG2:0]   r_level;
    logic                  r_in_ready;
    logic [2:0]            r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic [SIZE-1:0]       r_d_out;
    logic                  r_oe;
    logic                  r_wr_n;
    logic                  r_busy;

    logic                  w_push;
    logic                  w_pop;
    logic                  w_can_start;
    logic [2:0]            w_state_next;
    logic [CNT_W-1:0]      w_cnt_next;
    logic [DEPTH_LOG2:0]   w_level_next;

    assign in_ready   = r_in_ready;
    assign ftdi_d_out = r_d_out;
    assign ftdi_d_oe  = r_oe;
    assign ftdi_wr_n  = r_wr_n;
    assign busy       = r_busy;
    assign level      = r_level;

    // Two-flop synchronizer for the asynchronous TXE# pin
    always_ff @(posedge clk) begin
        if (rst) begin
            r_txe_meta <= 1'b1;
            r_txe_s    <= 1'b1;
        end else begin
            r_txe_meta <= ftdi_txe_n;
            r_txe_s    <= r_txe_meta;
        end
    end

    // Next state; a finished RECOVER may chain straight into the next SETUP
    always_comb begin
        w_push       = in_valid & r_in_ready;
        w_can_start  = (r_level != LVL_ZERO) && (r_txe_s == 1'b0);
        w_pop        = 1'b0;
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_can_start) begin
                    w_pop        = 1'b1;
                    w_state_next = S_SETUP;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            S_SETUP: begin
                w_state_next = S_STROBE;
                w_cnt_next   = STROBE_LOAD;
            end
            S_STROBE: begin
                if (r_cnt == CNT_ZERO) begin
                    w_state_next = S_HOLD;
                end else begin
                    w_cnt_next = r_cnt - CNT_ONE;
                end
            end
            S_HOLD: begin
                w_state_next = S_RECOVER;
                w_cnt_next   = RECOV_LOAD;
            end
            S_RECOVER: begin
                if (r_cnt != CNT_ZERO) begin
                    w_cnt_next = r_cnt - CNT_ONE;
                end else if (w_can_start) begin
                    w_pop        = 1'b1;
                    w_state_next = S_SETUP;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
                w_cnt_next   = CNT_ZERO;
            end
        endcase
    end

    // Occupancy follows push/pop; both together leave it unchanged
    always_comb begin
        case ({w_push, w_pop})
            2'b10:   w_level_next = r_level + LVL_ONE;
            2'b01:   w_level_next = r_level - LVL_ONE;
            default: w_level_next = r_level;
        endcase
    end

    // Buffer storage, no reset needed since reads are gated by occupancy
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= in_b;
        end
    end

    // Circular pointers, occupancy and registered ready flag
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr     <= DEPTH_LOG2'(0);
            r_rptr     <= DEPTH_LOG2'(0);
            r_level    <= LVL_ZERO;
            r_in_ready <= 1'b0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + DEPTH_LOG2'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + DEPTH_LOG2'(1);
            end
            r_level    <= w_level_next;
            r_in_ready <= (w_level_next != LVL_FULL);
        end
    end

    // FSM state and pad outputs, registered from the next state
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= CNT_ZERO;
            r_d_out <= SIZE'(0);
            r_oe    <= 1'b0;
            r_wr_n  <= 1'b1;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            if (w_pop) begin
                r_d_out <= r_mem[r_rptr];
            end
            r_oe   <= (w_state_next == S_SETUP) || (w_state_next == S_STROBE) ||
                      (w_state_next == S_HOLD);
            r_wr_n <= (w_state_next != S_STROBE);
            r_busy <= (w_level_next != LVL_ZERO) || (w_state_next != S_IDLE);
        end
    end

`ifdef FTDI_TX_SIWU_EN
    logic             r_pend;
    logic             r_siwu_act;
    logic             r_siwu_n;
    logic [CNT_W-1:0] r_siwu_cnt;

    assign ftdi_siwu_n = r_siwu_n;

    // Sticky flush request fires one SIWU# pulse once everything has drained
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend     <= 1'b0;
            r_siwu_act <= 1'b0;
            r_siwu_n   <= 1'b1;
            r_siwu_cnt <= CNT_ZERO;
        end else if (r_siwu_act) begin
            if (r_siwu_cnt == CNT_ZERO) begin
                r_siwu_act <= 1'b0;
                r_siwu_n   <= 1'b1;
                r_pend     <= 1'b0;
            end else begin
                r_siwu_cnt <= r_siwu_cnt - CNT_ONE;
            end
        end else if (r_pend && (r_level == LVL_ZERO) && (r_state == S_IDLE)) begin
            r_siwu_act <= 1'b1;
            r_siwu_n   <= 1'b0;
            r_siwu_cnt <= STROBE_LOAD;
        end else begin
            r_pend <= r_pend | flush;
        end
    end
`endif

endmodule

// File: tb/tb_ftdi_fifo_tx.sv
// Directed self-checking bench for ftdi_fifo_tx (default parameters).
module tb_ftdi_fifo_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] in_b;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] ftdi_d_out;
    logic       ftdi_d_oe;
    logic       ftdi_wr_n;
    logic       ftdi_txe_n;
    logic       busy;
    logic [2:0] level;
`ifdef FTDI_TX_SIWU_EN
    logic       flush;
    logic       ftdi_siwu_n;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ftdi_fifo_tx dut (
        .clk        (clk),
        .rst        (rst),
        .in_b       (in_b),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .ftdi_d_out (ftdi_d_out),
        .ftdi_d_oe  (ftdi_d_oe),
        .ftdi_wr_n  (ftdi_wr_n),
        .ftdi_txe_n (ftdi_txe_n),
`ifdef FTDI_TX_SIWU_EN
        .flush      (flush),
        .ftdi_siwu_n(ftdi_siwu_n),
`endif
        .busy       (busy),
        .level      (level)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick();
        tick();
        total++; if (ftdi_wr_n !== 1'b1) begin bad++; $display("FAIL rst_wr_n got=%b want=1", ftdi_wr_n); end
        total++; if (ftdi_d_oe !== 1'b0) begin bad++; $display("FAIL rst_oe got=%b want=0", ftdi_d_oe); end
        total++; if (ftdi_d_out !== 8'h00) begin bad++; $display("FAIL rst_dout got=%h want=00", ftdi_d_out); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rst_ready got=%b want=0", in_ready); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", busy); end
        total++; if (level !== 3'd0) begin bad++; $display("FAIL rst_level got=%0d want=0", level); end
        rst = 1'b0;
        tick();
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_release_ready got=%b want=1", in_ready); end
        tick();
        tick();
    endtask

    task automatic test_single;
        int cyc;
        int first_low;
        int low;
        bit done;
        in_b = 8'hA5; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        cyc = 2;
        total++; if (level !== 3'd1) begin bad++; $display("FAIL single_level got=%0d want=1", level); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL single_busy got=%b want=1", busy); end
        tick(); cyc = 3;
        total++; if (ftdi_d_oe !== 1'b1 || ftdi_d_out !== 8'hA5 || ftdi_wr_n !== 1'b1)
            begin bad++; $display("FAIL single_setup got oe=%b d=%h wr=%b want oe=1 d=a5 wr=1", ftdi_d_oe, ftdi_d_out, ftdi_wr_n); end
        first_low = 0; low = 0; done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            tick(); cyc++;
            if (ftdi_wr_n == 1'b0) begin
                if (first_low == 0) first_low = cyc;
                low++;
            end else if (low > 0) begin
                done = 1'b1;
            end
        end
        total++; if (!done) begin bad++; $display("FAIL single_strobe_timeout got=%0d want=done", low); end
        total++; if (first_low != 4) begin bad++; $display("FAIL single_latency got=%0d want=4", first_low); end
        total++; if (low != 3) begin bad++; $display("FAIL single_wr_low got=%0d want=3", low); end
        total++; if (ftdi_d_oe !== 1'b1 || ftdi_d_out !== 8'hA5)
            begin bad++; $display("FAIL single_hold got oe=%b d=%h want oe=1 d=a5", ftdi_d_oe, ftdi_d_out); end
        tick();
        total++; if (ftdi_d_oe !== 1'b0 || busy !== 1'b1)
            begin bad++; $display("FAIL single_recover got oe=%b busy=%b want oe=0 busy=1", ftdi_d_oe, busy); end
        tick();
        tick();
        total++; if (busy !== 1'b0 || level !== 3'd0)
            begin bad++; $display("FAIL single_idle got busy=%b level=%0d want 0 0", busy, level); end
    endtask

    task automatic test_full_order;
        logic [7:0] caps [5];
        int capcyc [5];
        int ncap;
        bit quiet;
        bit accepted5;
        bit prev;
        bit rdy;
        ftdi_txe_n = 1'b1;
        tick(); tick(); tick();
        for (int k = 1; k <= 5; k++) begin
            in_b = 8'(k); in_valid = 1'b1;
            tick();
        end
        total++; if (level !== 3'd4 || in_ready !== 1'b0)
            begin bad++; $display("FAIL full_level got level=%0d ready=%b want 4 0", level, in_ready); end
        quiet = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (ftdi_wr_n == 1'b0) quiet = 1'b0;
        end
        total++; if (!quiet || level !== 3'd4)
            begin bad++; $display("FAIL full_txe_high got quiet=%b level=%0d want 1 4", quiet, level); end
        ftdi_txe_n = 1'b0;
        ncap = 0; accepted5 = 1'b0; prev = ftdi_wr_n;
        for (int i = 0; i < 120 && ncap < 5; i++) begin
            rdy = in_ready;
            tick();
            if (in_valid && rdy) begin accepted5 = 1'b1; in_valid = 1'b0; end
            if (prev && !ftdi_wr_n) begin caps[ncap] = ftdi_d_out; capcyc[ncap] = i; ncap++; end
            prev = ftdi_wr_n;
        end
        in_valid = 1'b0;
        total++; if (ncap != 5) begin bad++; $display("FAIL full_count got=%0d want=5", ncap); end
        total++; if (!accepted5) begin bad++; $display("FAIL full_accept5 got=0 want=1"); end
        for (int j = 0; j < 5; j++) begin
            total++; if (caps[j] !== 8'(j + 1)) begin bad++; $display("FAIL full_order[%0d] got=%h want=%h", j, caps[j], 8'(j + 1)); end
        end
        for (int j = 1; j < 4; j++) begin
            total++; if (capcyc[j] - capcyc[j-1] != 7)
                begin bad++; $display("FAIL full_spacing[%0d] got=%0d want=7", j, capcyc[j] - capcyc[j-1]); end
        end
    endtask

    task automatic test_txe_glitch;
        int low;
        bit quiet;
        bit seen;
        for (int i = 0; i < 50 && busy; i++) tick();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL glitch_idle_timeout got=%b want=0", busy); end
        in_b = 8'h3C; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 20 && ftdi_wr_n; i++) tick();
        total++; if (ftdi_wr_n !== 1'b0 || ftdi_d_out !== 8'h3C)
            begin bad++; $display("FAIL glitch_start got wr=%b d=%h want 0 3c", ftdi_wr_n, ftdi_d_out); end
        low = 1;
        for (int i = 0; i < 10; i++) begin
            ftdi_txe_n = (i == 0) ? 1'b1 : 1'b0;
            tick();
            if (ftdi_wr_n == 1'b0) low++;
            else break;
        end
        total++; if (low != 3) begin bad++; $display("FAIL glitch_wr_low got=%0d want=3", low); end
        for (int i = 0; i < 50 && busy; i++) tick();
        ftdi_txe_n = 1'b1;
        tick(); tick(); tick();
        in_b = 8'h4D; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        quiet = 1'b1;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (ftdi_wr_n == 1'b0 || ftdi_d_oe == 1'b1) quiet = 1'b0;
        end
        total++; if (!quiet || level !== 3'd1 || busy !== 1'b1)
            begin bad++; $display("FAIL glitch_wait got quiet=%b level=%0d busy=%b want 1 1 1", quiet, level, busy); end
        ftdi_txe_n = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick();
            if (ftdi_wr_n == 1'b0) seen = 1'b1;
        end
        total++; if (!seen || ftdi_d_out !== 8'h4D)
            begin bad++; $display("FAIL glitch_resume got seen=%b d=%h want 1 4d", seen, ftdi_d_out); end
    endtask

    task automatic test_wrap;
        logic [7:0] seq [10];
        logic [7:0] caps [10];
        int ncap;
        int npush;
        int rel;
        bit found;
        bit pushed;
        bit prev;
        for (int k = 0; k < 10; k++) seq[k] = 8'h80 + 8'(k * 3);
        for (int i = 0; i < 50 && busy; i++) tick();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL wrap_idle_timeout got=%b want=0", busy); end
        ftdi_txe_n = 1'b1;
        tick(); tick(); tick();
        for (int k = 0; k < 2; k++) begin
            in_b = seq[k]; in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        ftdi_txe_n = 1'b0;
        ncap = 0; npush = 2; rel = 0; found = 1'b0; prev = ftdi_wr_n;
        for (int i = 0; i < 150 && ncap < 10; i++) begin
            pushed = 1'b0;
            if (found && npush < 10 && (rel == 0 || rel % 7 == 6)) begin
                in_b = seq[npush]; in_valid = 1'b1; pushed = 1'b1;
            end
            tick();
            in_valid = 1'b0;
            if (pushed) begin
                npush++;
                total++; if (level !== 3'd2) begin bad++; $display("FAIL wrap_level[%0d] got=%0d want=2", npush - 1, level); end
            end
            if (found) rel++;
            else if (ftdi_d_oe) found = 1'b1;
            if (prev && !ftdi_wr_n) begin caps[ncap] = ftdi_d_out; ncap++; end
            prev = ftdi_wr_n;
        end
        total++; if (ncap != 10) begin bad++; $display("FAIL wrap_count got=%0d want=10", ncap); end
        for (int j = 0; j < 10; j++) begin
            total++; if (caps[j] !== seq[j]) begin bad++; $display("FAIL wrap_order[%0d] got=%h want=%h", j, caps[j], seq[j]); end
        end
    endtask

    task automatic test_reset_mid;
        bit quiet;
        int low;
        for (int i = 0; i < 50 && busy; i++) tick();
        ftdi_txe_n = 1'b0;
        in_b = 8'h55; in_valid = 1'b1;
        tick();
        in_b = 8'h66;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 20 && ftdi_wr_n; i++) tick();
        tick();
        total++; if (ftdi_wr_n !== 1'b0) begin bad++; $display("FAIL rmid_in_strobe got=%b want=0", ftdi_wr_n); end
        rst = 1'b1;
        tick();
        total++; if (ftdi_wr_n !== 1'b1 || ftdi_d_oe !== 1'b0)
            begin bad++; $display("FAIL rmid_pins got wr=%b oe=%b want 1 0", ftdi_wr_n, ftdi_d_oe); end
        total++; if (level !== 3'd0 || in_ready !== 1'b0 || busy !== 1'b0)
            begin bad++; $display("FAIL rmid_state got level=%0d ready=%b busy=%b want 0 0 0", level, in_ready, busy); end
        rst = 1'b0;
        quiet = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (ftdi_wr_n == 1'b0 || ftdi_d_oe == 1'b1 || busy == 1'b1) quiet = 1'b0;
        end
        total++; if (!quiet || level !== 3'd0)
            begin bad++; $display("FAIL rmid_no_partial got quiet=%b level=%0d want 1 0", quiet, level); end
        in_b = 8'h77; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 20 && ftdi_wr_n; i++) tick();
        total++; if (ftdi_wr_n !== 1'b0 || ftdi_d_out !== 8'h77)
            begin bad++; $display("FAIL rmid_resume got wr=%b d=%h want 0 77", ftdi_wr_n, ftdi_d_out); end
        low = 1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (ftdi_wr_n == 1'b0) low++;
            else break;
        end
        total++; if (low != 3) begin bad++; $display("FAIL rmid_wr_low got=%0d want=3", low); end
    endtask

`ifdef FTDI_TX_SIWU_EN
    task automatic test_siwu;
        int low;
        int falls;
        int early;
        int wrfalls;
        int wr_at_siwu;
        bit prev_s;
        bit prev_w;
        for (int i = 0; i < 50 && busy; i++) tick();
        ftdi_txe_n = 1'b0;
        in_b = 8'hAA; in_valid = 1'b1;
        tick();
        in_b = 8'hBB;
        tick();
        in_valid = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        low = 0; falls = 0; early = 0; wrfalls = 0; wr_at_siwu = -1;
        prev_s = ftdi_siwu_n; prev_w = ftdi_wr_n;
        for (int i = 0; i < 80; i++) begin
            flush = (low == 1) ? 1'b1 : 1'b0;
            tick();
            if (prev_w && !ftdi_wr_n) wrfalls++;
            if (!ftdi_siwu_n) begin
                low++;
                if (busy) early++;
                if (prev_s) begin falls++; wr_at_siwu = wrfalls; end
            end
            prev_s = ftdi_siwu_n; prev_w = ftdi_wr_n;
        end
        flush = 1'b0;
        total++; if (low != 3) begin bad++; $display("FAIL siwu_low got=%0d want=3", low); end
        total++; if (falls != 1) begin bad++; $display("FAIL siwu_pulses got=%0d want=1", falls); end
        total++; if (early != 0) begin bad++; $display("FAIL siwu_while_busy got=%0d want=0", early); end
        total++; if (wr_at_siwu != 2) begin bad++; $display("FAIL siwu_after_bytes got=%0d want=2", wr_at_siwu); end
    endtask
`endif

    initial begin
        rst = 1'b1; in_b = 8'h00; in_valid = 1'b0; ftdi_txe_n = 1'b0;
`ifdef FTDI_TX_SIWU_EN
        flush = 1'b0;
`endif
        test_reset();
        test_single();
        test_full_order();
        test_txe_glitch();
        test_wrap();
        test_reset_mid();
`ifdef FTDI_TX_SIWU_EN
        test_siwu();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
